// File: rtl/hdmi_pll_reconfig_seq.sv
// Sequences an Avalon-MM PLL reconfiguration for one of four HDMI pixel-clock modes,
// then polls the status register and optionally waits for PLL lock before reporting done/error.
module hdmi_pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int POLL_LIMIT    = 4096,
    parameter int WAIT_FOR_LOCK = 1
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset_n,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    input  logic [31:0] mgmt_readdata,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [8:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  cur_mode
);

    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, RD_STATUS, WAIT_LOCK, DONE, ERR
    } state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [PW-1:0]   poll_cnt;
    logic [LW-1:0]   lock_cnt;

    // Only bit 0 of the status word carries meaning.
    logic unused_rd;
    assign unused_rd = ^mgmt_readdata[31:1];

    function automatic logic [8:0] cfg_addr(input state_t s);
        case (s)
            WR_MODE:   cfg_addr = 9'h000;
            WR_N:      cfg_addr = 9'h003;
            WR_M:      cfg_addr = 9'h004;
            WR_C0:     cfg_addr = 9'h005;
            WR_START:  cfg_addr = 9'h002;
            RD_STATUS: cfg_addr = 9'h001;
            default:   cfg_addr = 9'h000;
        endcase
    endfunction

    function automatic logic [31:0] cfg_word(input state_t s, input logic [1:0] m);
        cfg_word = 32'h0000_0001;
        case (s)
            WR_N:  cfg_word = (m == 2'd0) ? 32'h0001_0000 : 32'h0000_0302;
            WR_M:  case (m)
                       2'd0:    cfg_word = 32'h0000_1414;
                       2'd1:    cfg_word = 32'h0000_2D2D;
                       default: cfg_word = 32'h0000_2C2C;
                   endcase
            WR_C0: case (m)
                       2'd0:    cfg_word = 32'h0000_2020;
                       2'd1:    cfg_word = 32'h0000_1514;
                       2'd2:    cfg_word = 32'h0000_0706;
                       default: cfg_word = 32'h0002_0403;
                   endcase
            default: cfg_word = 32'h0000_0001;
        endcase
    endfunction

    function automatic state_t next_wr(input state_t s);
        case (s)
            WR_MODE: next_wr = WR_N;
            WR_N:    next_wr = WR_M;
            WR_M:    next_wr = WR_C0;
            WR_C0:   next_wr = WR_START;
            default: next_wr = RD_STATUS;
        endcase
    endfunction

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            state          <= IDLE;
            mode_q         <= 2'd0;
            poll_cnt       <= '0;
            lock_cnt       <= '0;
            mgmt_read      <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 9'h000;
            mgmt_writedata <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cur_mode       <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (mode_req) begin
                    mode_q   <= mode_sel;
                    error    <= 1'b0;
                    busy     <= 1'b1;
                    poll_cnt <= '0;
                    lock_cnt <= '0;
                    state    <= WR_MODE;
                end
                // Command is raised one cycle after entering a state, so it is
                // always low for at least one cycle between back-to-back transfers.
                WR_MODE, WR_N, WR_M, WR_C0, WR_START: begin
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= cfg_addr(state);
                        mgmt_writedata <= cfg_word(state, mode_q);
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= next_wr(state);
                    end
                end
                RD_STATUS: begin
                    if (!mgmt_read) begin
                        mgmt_read    <= 1'b1;
                        mgmt_address <= cfg_addr(state);
                    end else if (!mgmt_waitrequest) begin
                        mgmt_read <= 1'b0;
                        if (mgmt_readdata[0]) begin
                            if (WAIT_FOR_LOCK != 0) begin
                                lock_cnt <= '0;
                                state    <= WAIT_LOCK;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else if (poll_cnt == POLL_MAX) begin
                            state <= ERR;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                WAIT_LOCK: begin
                    if (pll_locked) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (lock_cnt == LOCK_MAX) begin
                        state <= ERR;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    cur_mode <= mode_q;
                    state    <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_pll_reconfig_seq.sv
// Directed bench: table of per-mode programming sequences plus hand-written stall, poll, lock, request-while-busy and reset cases.
module tb_hdmi_pll_reconfig_seq;

    localparam int POLL_L = 8;
    localparam int LOCK_T = 16;

    logic        clk = 1'b0;
    logic        mgmt_reset_n = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_req = 1'b0;
    logic        pll_locked = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_read, mgmt_write;
    logic [8:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        busy, done, error;
    logic [1:0]  cur_mode;

    logic        status_bit = 1'b1;
    assign mgmt_readdata = {31'h2AAA_5555, status_bit};

    always #5 clk = ~clk;

    hdmi_pll_reconfig_seq #(
        .LOCK_TIMEOUT(LOCK_T),
        .POLL_LIMIT(POLL_L),
        .WAIT_FOR_LOCK(1)
    ) dut (
        .mgmt_clk(clk),
        .mgmt_reset_n(mgmt_reset_n),
        .mode_sel(mode_sel),
        .mode_req(mode_req),
        .pll_locked(pll_locked),
        .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_readdata(mgmt_readdata),
        .mgmt_read(mgmt_read),
        .mgmt_write(mgmt_write),
        .mgmt_address(mgmt_address),
        .mgmt_writedata(mgmt_writedata),
        .busy(busy),
        .done(done),
        .error(error),
        .cur_mode(cur_mode)
    );

    int checks = 0;
    int failures = 0;

    int          stall_left = 0;
    logic [8:0]  stall_addr = 9'h000;
    int          n_wr = 0, n_rd = 0, done_cnt = 0, cmd_cyc = 0;
    int          hold_cyc = 0, hold_ok = 0, cyc = 0, rd_cyc = 0;
    logic [40:0] wr_q[$];

    // Slave model: drives waitrequest for the next edge and logs completing transfers.
    always @(negedge clk) begin
        cyc++;
        if ((mgmt_write || mgmt_read) && stall_left > 0 && mgmt_address == stall_addr) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
        if (mgmt_write || mgmt_read) cmd_cyc++;
        if (mgmt_write && mgmt_address == 9'h004) begin
            hold_cyc++;
            if (mgmt_writedata == 32'h0000_2C2C) hold_ok++;
        end
        if (mgmt_write && !mgmt_waitrequest) begin
            n_wr++;
            wr_q.push_back({mgmt_address, mgmt_writedata});
        end
        if (mgmt_read && !mgmt_waitrequest) begin
            n_rd++;
            rd_cyc = cyc;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_wr = 0; n_rd = 0; done_cnt = 0; cmd_cyc = 0;
        hold_cyc = 0; hold_ok = 0;
        wr_q.delete();
    endtask

    task automatic pulse_req(input logic [1:0] m);
        @(posedge clk); #1;
        mode_sel = m;
        mode_req = 1'b1;
        @(posedge clk); #1;
        mode_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 300 && busy; c++) @(negedge clk);
        check({name, "_idle"}, busy, 0);
        @(negedge clk); #1;
    endtask

    task automatic wait_addr(input string name, input logic [8:0] a);
        for (int c = 0; c < 100 && !(mgmt_write && mgmt_address == a); c++) begin
            @(negedge clk); #1;
        end
        check({name, "_seen"}, mgmt_write && mgmt_address == a, 1);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] n, m, c0;
    } vec_t;

    vec_t        tbl[4];
    logic [8:0]  ea[5];
    logic [31:0] ed[5];
    logic [40:0] got;
    int          err_cyc;

    initial begin
        tbl[0] = '{2'd2, 32'h0000_0302, 32'h0000_2C2C, 32'h0000_0706};
        tbl[1] = '{2'd0, 32'h0001_0000, 32'h0000_1414, 32'h0000_2020};
        tbl[2] = '{2'd3, 32'h0000_0302, 32'h0000_2C2C, 32'h0002_0403};
        tbl[3] = '{2'd1, 32'h0000_0302, 32'h0000_2D2D, 32'h0000_1514};

        #3;
        check("reset_outputs", {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata,
                                busy, done, error, cur_mode}, 0);
        @(posedge clk); @(posedge clk); #1;
        mgmt_reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_no_cmd", cmd_cyc, 0);

        // Normal programming of every mode.
        for (int t = 0; t < 4; t++) begin
            ea = '{9'h000, 9'h003, 9'h004, 9'h005, 9'h002};
            ed = '{32'h1, tbl[t].n, tbl[t].m, tbl[t].c0, 32'h1};
            clr();
            pulse_req(tbl[t].mode);
            check($sformatf("v%0d_busy", t), busy, 1);
            wait_idle($sformatf("v%0d", t));
            check($sformatf("v%0d_nwr", t), n_wr, 5);
            for (int i = 0; i < 5; i++) begin
                got = (i < wr_q.size()) ? wr_q[i] : '1;
                check($sformatf("v%0d_wr%0d", t, i), got, {ea[i], ed[i]});
            end
            check($sformatf("v%0d_nrd", t), n_rd, 1);
            check($sformatf("v%0d_done", t), done_cnt, 1);
            check($sformatf("v%0d_mode", t), cur_mode, tbl[t].mode);
            check($sformatf("v%0d_err", t), error, 0);
        end

        // Waitrequest stall during WR_M.
        clr();
        stall_addr = 9'h004; stall_left = 3;
        pulse_req(2'd2);
        wait_idle("stall");
        check("stall_hold_cycles", hold_cyc, 4);
        check("stall_hold_data", hold_ok, 4);
        check("stall_nwr", n_wr, 5);
        got = (wr_q.size() > 2) ? wr_q[2] : '1;
        check("stall_wr_m", got, {9'h004, 32'h0000_2C2C});
        check("stall_done", done_cnt, 1);

        // Status bit stuck low: poll limit.
        clr();
        status_bit = 1'b0;
        pulse_req(2'd3);
        wait_idle("poll");
        status_bit = 1'b1;
        check("poll_nrd", n_rd, POLL_L);
        check("poll_err", error, 1);
        check("poll_done", done_cnt, 0);
        check("poll_mode", cur_mode, 2);

        // No lock: timeout, then a new request clears error.
        clr();
        pll_locked = 1'b0;
        pulse_req(2'd0);
        err_cyc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (error) begin
                err_cyc = cyc;
                break;
            end
        end
        check("lock_err", error, 1);
        // 16 WAIT_LOCK cycles plus the ERR cycle, counted from the negedge before the read completes.
        check("lock_timing", err_cyc - rd_cyc, LOCK_T + 2);
        check("lock_busy", busy, 0);
        check("lock_done", done_cnt, 0);
        check("lock_mode", cur_mode, 2);
        pll_locked = 1'b1;
        clr();
        pulse_req(2'd0);
        check("lock_err_cleared", error, 0);
        wait_idle("relock");
        check("relock_mode", cur_mode, 0);
        check("relock_done", done_cnt, 1);

        // Second request while busy in WR_N is dropped.
        clr();
        stall_addr = 9'h003; stall_left = 4;
        pulse_req(2'd3);
        wait_addr("busyreq", 9'h003);
        pulse_req(2'd1);
        wait_idle("busyreq");
        repeat (5) @(negedge clk);
        #1;
        check("busyreq_nwr", n_wr, 5);
        got = (wr_q.size() > 3) ? wr_q[3] : '1;
        check("busyreq_c0", got, {9'h005, 32'h0002_0403});
        check("busyreq_mode", cur_mode, 3);
        check("busyreq_done", done_cnt, 1);

        // Asynchronous reset while WR_C0 is stalled.
        clr();
        stall_addr = 9'h005; stall_left = 1000;
        pulse_req(2'd2);
        wait_addr("rst", 9'h005);
        #2;
        mgmt_reset_n = 1'b0;
        #1;
        check("rst_write", mgmt_write, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mgmt_address, 0);
        @(posedge clk); @(posedge clk); #1;
        stall_left = 0;
        mgmt_reset_n = 1'b1;
        clr();
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_cmd", cmd_cyc, 0);
        check("rst_mode", cur_mode, 0);
        check("rst_state", {busy, error, done_cnt[0]}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
